// File: rtl/adder_display.sv
// Captures the 4-bit adder result {carry, out}, splits it into decimal digits with a
// subtract-by-ten engine, and drives a multiplexed 2-digit 7-segment display.
module adder_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum_in,
  input  logic       carry_in,
  input  logic       load,
  output logic       busy,
  output logic [4:0] value_q,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [4:0]    value_reg;
  logic [4:0]    rem_reg;
  logic [1:0]    tens_reg;
  logic [1:0]    disp_tens_reg;
  logic [3:0]    disp_ones_reg;
  logic [CW-1:0] cnt_reg;
  logic          dig_sel_reg;
  logic          capture;
  logic          commit;
  logic [3:0]    digit;
  logic [6:0]    seg_on;
  logic [1:0]    dig_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (rem_reg < 5'd10) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg == CONV);
    capture = (state_reg == IDLE) && load;
    commit  = (state_reg == CONV) && (rem_reg < 5'd10);
  end

  // Old digits stay visible until the conversion commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg     <= 5'd0;
      rem_reg       <= 5'd0;
      tens_reg      <= 2'd0;
      disp_tens_reg <= 2'd0;
      disp_ones_reg <= 4'd0;
    end else if (capture) begin
      value_reg <= {carry_in, sum_in};
      rem_reg   <= {carry_in, sum_in};
      tens_reg  <= 2'd0;
    end else if (commit) begin
      disp_tens_reg <= tens_reg;
      disp_ones_reg <= rem_reg[3:0];
    end else if (state_reg == CONV) begin
      rem_reg  <= rem_reg - 5'd10;
      tens_reg <= tens_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      dig_sel_reg <= 1'b0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg     <= '0;
      dig_sel_reg <= ~dig_sel_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Outputs decode registers only, so they cannot glitch on input activity.
  always_comb begin
    digit  = dig_sel_reg ? {2'b00, disp_tens_reg} : disp_ones_reg;
    dig_on = dig_sel_reg ? 2'b10 : 2'b01;
    case (digit)
      4'd0:    seg_on = 7'b0111111;
      4'd1:    seg_on = 7'b0000110;
      4'd2:    seg_on = 7'b1011011;
      4'd3:    seg_on = 7'b1001111;
      4'd4:    seg_on = 7'b1100110;
      4'd5:    seg_on = 7'b1101101;
      4'd6:    seg_on = 7'b1111101;
      4'd7:    seg_on = 7'b0000111;
      4'd8:    seg_on = 7'b1111111;
      4'd9:    seg_on = 7'b1101111;
      default: seg_on = 7'b0000000;
    endcase
    if (dig_sel_reg && (disp_tens_reg == 2'd0)) seg_on = 7'b0000000;
  end

  assign value_q = value_reg;
  assign seg     = {7{SEG_ACTIVE_LOW}} ^ seg_on;
  assign dig     = {2{SEG_ACTIVE_LOW}} ^ dig_on;

endmodule

// File: tb/tb_adder_display.sv
// Directed bench for adder_display: scoreboard of expected conversions, checked when busy falls.
module tb_adder_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sum_in = 4'd0;
  logic       carry_in = 1'b0;
  logic       load = 1'b0;
  logic       busy;
  logic [4:0] value_q;
  logic [6:0] seg;
  logic [1:0] dig;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0] value;
    int         n;
    logic [6:0] tens_seg;
    logic [6:0] ones_seg;
  } exp_t;

  exp_t sb[$];
  logic [6:0] codes [10];
  localparam logic [6:0] BLANK = 7'b1111111;

  adder_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .carry_in(carry_in), .load(load),
    .busy(busy), .value_q(value_q), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] c;
    c = codes[d];
    return ~c;
  endfunction

  function automatic exp_t make_exp(input logic [4:0] v);
    exp_t e;
    int t;
    t = int'(v) / 10;
    e.value    = v;
    e.n        = t + 1;
    e.tens_seg = (t == 0) ? BLANK : seg_of(t);
    e.ones_seg = seg_of(int'(v) % 10);
    return e;
  endfunction

  // Samples seg once while each digit is enabled.
  task automatic check_display(input string tag, input logic [6:0] t_seg, input logic [6:0] o_seg);
    bit got_t = 0;
    bit got_o = 0;
    for (int i = 0; i < 12 && !(got_t && got_o); i++) begin
      if (dig === 2'b01 && !got_t) begin
        check({tag, "_tens_seg"}, seg, t_seg);
        got_t = 1;
      end else if (dig === 2'b10 && !got_o) begin
        check({tag, "_ones_seg"}, seg, o_seg);
        got_o = 1;
      end
      @(negedge clk);
    end
    if (!got_t) timeout({tag, "_tens_dig"});
    if (!got_o) timeout({tag, "_ones_dig"});
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_value"}, value_q, 5'd0);
    check({tag, "_dig"}, dig, 2'b10);
    check({tag, "_seg"}, seg, 7'b1000000);
  endtask

  // Starts a conversion at a negedge; optionally pokes a stray load or a reset at busy cycle k.
  task automatic convert(input string tag, input logic [4:0] v, input int poke_cycle, input int rst_cycle);
    exp_t e;
    int cycles = 0;
    bit aborted = 0;
    sum_in = v[3:0];
    carry_in = v[4];
    load = 1'b1;
    sb.push_back(make_exp(v));
    @(negedge clk);
    load = 1'b0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (cycles == rst_cycle) begin
        rst_n = 1'b0;
        #1;
        reset_checks({tag, "_midreset"});
        aborted = 1;
        break;
      end
      if (cycles == poke_cycle) begin
        load = 1'b1;
        sum_in = 4'd7;
        carry_in = 1'b0;
      end
      @(negedge clk);
      load = 1'b0;
    end
    e = sb.pop_front();
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      check_display({tag, "_after_reset"}, BLANK, seg_of(0));
    end else if (cycles >= 40) begin
      timeout({tag, "_busy_fall"});
    end else begin
      check({tag, "_busy_cycles"}, cycles, e.n);
      check({tag, "_value"}, value_q, e.value);
      check_display(tag, e.tens_seg, e.ones_seg);
    end
    $display("conv %s: value %0d busy_cycles %0d aborted %0d", tag, v, cycles, aborted);
  endtask

  // Holds load high and checks spacing between busy rises.
  task automatic held_load(input string tag, input logic [4:0] v, input int gap);
    int rises[$];
    logic prev;
    sum_in = v[3:0];
    carry_in = v[4];
    load = 1'b1;
    repeat (4) @(negedge clk);
    prev = busy;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && prev === 1'b0) rises.push_back(c);
      prev = busy;
    end
    if (rises.size() < 2) timeout({tag, "_rises"});
    for (int i = 1; i < rises.size(); i++) check({tag, "_gap"}, rises[i] - rises[i-1], gap);
    check({tag, "_value"}, value_q, v);
    $display("held %s: value %0d captures %0d", tag, v, rises.size());
  endtask

  initial begin
    int toggles[$];
    logic [1:0] prev_dig;
    codes = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    // 1. reset state and refresh cadence
    #1;
    reset_checks("reset_held");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_dig = dig;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (dig !== prev_dig) toggles.push_back(c);
      prev_dig = dig;
      check("reset_busy", busy, 1'b0);
    end
    if (toggles.size() < 2) timeout("refresh_toggles");
    for (int i = 1; i < toggles.size(); i++) check("refresh_gap", toggles[i] - toggles[i-1], 4);
    check("reset_value", value_q, 5'd0);
    check_display("reset_disp", BLANK, seg_of(0));
    $display("reset: dig toggles %0d", toggles.size());

    // 2..4. conversions including a stray load during busy
    convert("add_0_0", 5'd0, 0, 0);
    convert("add_5_5", 5'd10, 0, 0);
    convert("add_15_15", 5'd30, 2, 0);

    // 5. reset mid-conversion, then redo
    convert("v31_abort", 5'd31, 0, 2);
    convert("v31", 5'd31, 0, 0);

    // 6. load held high
    held_load("held9", 5'd9, 2);
    check_display("held9_disp", BLANK, seg_of(9));
    held_load("held10", 5'd10, 3);
    check_display("held10_disp", seg_of(1), seg_of(0));
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
